// File: rtl/i2s_rx_master_if.sv
// i2s_rx_master_if: microphone pins plus the sample valid/ready stream of the I2S receiver.
// The master modport is the receiver side; the slave modport is the mic/consumer side.
interface i2s_rx_master_if #(
    parameter int unsigned DATA_W = 24
) ();
    logic              sck_o;
    logic              ws_o;
    logic              sd_i;
    logic [DATA_W-1:0] sample_o;
    logic              sample_right_o;
    logic              sample_valid_o;
    logic              sample_ready_i;
    logic              overrun_o;

    modport master (
        output sck_o,
        output ws_o,
        input  sd_i,
        output sample_o,
        output sample_right_o,
        output sample_valid_o,
        input  sample_ready_i,
        output overrun_o
    );

    modport slave (
        input  sck_o,
        input  ws_o,
        output sd_i,
        input  sample_o,
        input  sample_right_o,
        input  sample_valid_o,
        output sample_ready_i,
        input  overrun_o
    );
endinterface

// File: rtl/i2s_rx_master.sv
// i2s_rx_master: I2S master receiver. Generates SCK (clk_in/2) and WS from a 7-bit frame
// counter, deserialises sd_i MSB-first from slots 1..DATA_W of each half-frame and presents
// the word on a valid/ready output register with a sticky overrun flag.
// Optional macro I2S_RX_STEREO_EN: emit right words too (default: left words only).
module i2s_rx_master #(
    parameter int unsigned DATA_W = 24
) (
    input  logic            clk_in,
    input  logic            reset,
    i2s_rx_master_if.master bus
);
    localparam logic [4:0] LastSlot = 5'(DATA_W);

    logic [6:0]        r_cnt;
    logic [6:0]        w_cnt_nxt;
    logic              r_sck;
    logic              r_ws;
    // Only DATA_W-1 bits are stored; the last bit comes straight from sd_i at completion.
    logic [DATA_W-2:0] r_shift;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] r_sample;
    logic              r_valid;
    logic              r_overrun;
    logic [4:0]        w_slot;
    logic              w_capture;
    logic              w_done;
    logic              w_offer;
    logic              w_free;
    logic              w_xfer;

    // Slot decode, capture/completion strobes and output-register handshake terms
    always_comb begin
        w_cnt_nxt = r_cnt + 7'd1;
        w_slot    = r_cnt[5:1];
        w_capture = r_cnt[0] && (w_slot != 5'd0) && (w_slot <= LastSlot);
        w_done    = r_cnt[0] && (w_slot == LastSlot);
        w_word    = {r_shift, bus.sd_i};
        w_free    = !r_valid || bus.sample_ready_i;
        w_xfer    = r_valid && bus.sample_ready_i;
    end

`ifdef I2S_RX_STEREO_EN
    logic r_right;

    assign w_offer = w_done;

    // Channel tag follows the half-frame in which the word completed
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_right <= 1'b0;
        end else if (w_offer && w_free) begin
            r_right <= r_cnt[6];
        end
    end

    assign bus.sample_right_o = r_right;
`else
    // Right half-frames are still clocked and shifted but never offered
    assign w_offer            = w_done && !r_cnt[6];
    assign bus.sample_right_o = 1'b0;
`endif

    // Frame counter; SCK and WS registered from the next count so they equal cnt[0]/cnt[6]
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_cnt <= 7'd0;
            r_sck <= 1'b0;
            r_ws  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_sck <= w_cnt_nxt[0];
            r_ws  <= w_cnt_nxt[6];
        end
    end

    // Shift sd_i in MSB-first during the data slots
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
        end else if (w_capture) begin
            r_shift <= w_word[DATA_W-2:0];
        end
    end

    // Output register: load when free, otherwise drop the new word and flag overrun
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_offer && w_free) begin
                r_sample <= w_word;
                r_valid  <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
            if (w_offer && !w_free) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.sck_o          = r_sck;
    assign bus.ws_o           = r_ws;
    assign bus.sample_o       = r_sample;
    assign bus.sample_valid_o = r_valid;
    assign bus.overrun_o      = r_overrun;

endmodule

// File: tb/tb_i2s_rx_master.sv
// tb_i2s_rx_master: two receivers (DATA_W=24 and 16) share clock, reset and one microphone
// model; a half-frame payload table drives sd_i and a protocol-level model predicts outputs.
module tb_i2s_rx_master;
`ifdef I2S_RX_STEREO_EN
    localparam bit Stereo = 1'b1;
`else
    localparam bit Stereo = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_in = ~clk_in;

    i2s_rx_master_if #(.DATA_W(24)) if24 ();
    i2s_rx_master_if #(.DATA_W(16)) if16 ();

    i2s_rx_master #(.DATA_W(24)) dut24 (.clk_in(clk_in), .reset(reset), .bus(if24));
    i2s_rx_master #(.DATA_W(16)) dut16 (.clk_in(clk_in), .reset(reset), .bus(if16));

    int          n_chk  = 0;
    int          n_fail = 0;
    int          t;              // clk_in edges since reset release == expected cnt (mod 128)
    logic [31:0] pay [64];       // per half-frame sd payload, bit 31 = slot 0
    logic        rdy [2];
    int          dw  [2] = '{24, 16};
    logic        ev  [2];
    logic        er  [2];
    logic        eov [2];
    logic [23:0] es  [2];

    typedef struct {
        logic [31:0] lpay;
        logic [31:0] rpay;
        logic [23:0] l24;
        logic [23:0] r24;
        logic [15:0] l16;
        logic [15:0] r16;
    } vec_t;

    vec_t vecs [3];

    // Word a DATA_W receiver extracts from a half-frame payload (slots 1..DATA_W)
    function automatic logic [23:0] word_of(input int k, input logic [31:0] p);
        if (k == 0) return p[30:7];
        return {8'h00, p[30:15]};
    endfunction

    // Cycle (value of t) at which the second offered word appears
    function automatic int second_load(input int k);
        return Stereo ? (64 + 2 * dw[k] + 2) : (128 + 2 * dw[k] + 2);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got %h want %h", nm, t, act, exp);
        end
    endtask

    task automatic check_outs();
        logic        sck, ws, vld, rt, ov;
        logic [23:0] smp;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                sck = if24.sck_o; ws = if24.ws_o; vld = if24.sample_valid_o;
                rt  = if24.sample_right_o; ov = if24.overrun_o; smp = if24.sample_o;
            end else begin
                sck = if16.sck_o; ws = if16.ws_o; vld = if16.sample_valid_o;
                rt  = if16.sample_right_o; ov = if16.overrun_o; smp = {8'h00, if16.sample_o};
            end
            chk($sformatf("sck[%0d]", k), sck, (t % 2) == 1);
            chk($sformatf("ws[%0d]", k), ws, (t % 128) >= 64);
            chk($sformatf("valid[%0d]", k), vld, ev[k]);
            chk($sformatf("sample[%0d]", k), smp, es[k]);
            chk($sformatf("right[%0d]", k), rt, er[k]);
            chk($sformatf("overrun[%0d]", k), ov, eov[k]);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            ev[k] = 1'b0; er[k] = 1'b0; eov[k] = 1'b0; es[k] = '0;
        end
        t = 0;
    endtask

    task automatic drive();
        int c, s, h;
        c = t % 128;
        s = (c % 64) / 2;
        h = (t / 64) % 64;
        if24.sd_i = pay[h][31-s];
        if16.sd_i = pay[h][31-s];
        if24.sample_ready_i = rdy[0];
        if16.sample_ready_i = rdy[1];
    endtask

    task automatic hard_reset();
        rdy[0] = 1'b0; rdy[1] = 1'b0;
        model_clear();
        drive();
        reset = 1'b1;
        @(posedge clk_in); #1;
        check_outs();
        reset = 1'b0;
    endtask

    // One clk_in cycle: drive mic bit and ready, advance the model, compare after the edge
    task automatic step();
        int          c, h;
        logic        nv, nr, nov, offer;
        logic [23:0] ns;
        logic        mv  [2];
        logic        mr  [2];
        logic        mov [2];
        logic [23:0] ms  [2];
        c = t % 128;
        h = (t / 64) % 64;
        drive();
        for (int k = 0; k < 2; k++) begin
            nv = ev[k]; nr = er[k]; nov = eov[k]; ns = es[k];
            offer = ((c % 64) == 2 * dw[k] + 1) && (Stereo || c < 64);
            if (ev[k] && rdy[k]) nv = 1'b0;
            if (offer) begin
                if (!ev[k] || rdy[k]) begin
                    nv = 1'b1; ns = word_of(k, pay[h]); nr = (c >= 64);
                end else begin
                    nov = 1'b1;
                end
            end
            mv[k] = nv; mr[k] = nr; mov[k] = nov; ms[k] = ns;
        end
        @(posedge clk_in); #1;
        t++;
        for (int k = 0; k < 2; k++) begin
            ev[k] = mv[k]; er[k] = mr[k]; eov[k] = mov[k]; es[k] = ms[k];
        end
        check_outs();
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) pay[i] = $urandom;
    endtask

    initial begin
        vecs[0] = '{{1'b0, 24'h800001, 7'h00}, {1'b1, 24'h7FFFFE, 7'h7F},
                    24'h800001, 24'h7FFFFE, 16'h8000, 16'h7FFF};
        vecs[1] = '{{1'b0, 16'hA5C3, 15'h7FFF}, {1'b0, 16'h1234, 15'h0000},
                    24'hA5C3FF, 24'h123400, 16'hA5C3, 16'h1234};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 24'hFFFFFF, 24'h000000, 16'hFFFF, 16'h0000};
        fill_random();

        // Table vectors: one frame each with ready held high
        for (int v = 0; v < 3; v++) begin
            pay[0] = vecs[v].lpay;
            pay[1] = vecs[v].rpay;
            hard_reset();
            rdy[0] = 1'b1; rdy[1] = 1'b1;
            while (t < 130) begin
                step();
                if (t == 50) begin
                    chk("tbl_l24_valid", if24.sample_valid_o, 1'b1);
                    chk("tbl_l24_data", if24.sample_o, vecs[v].l24);
                end
                if (t == 34) begin
                    chk("tbl_l16_valid", if16.sample_valid_o, 1'b1);
                    chk("tbl_l16_data", if16.sample_o, vecs[v].l16);
                end
                if (t == 114) begin
                    chk("tbl_r24_valid", if24.sample_valid_o, Stereo);
                    if (Stereo) chk("tbl_r24_data", if24.sample_o, vecs[v].r24);
                    if (Stereo) chk("tbl_r24_tag", if24.sample_right_o, 1'b1);
                end
                if (t == 98 && Stereo) chk("tbl_r16_data", if16.sample_o, vecs[v].r16);
            end
        end

        // Ready held low for four frames: first word held, later words dropped
        fill_random();
        hard_reset();
        while (t < 512) begin
            step();
            for (int k = 0; k < 2; k++) begin
                if (t == second_load(k) - 1)
                    chk($sformatf("ovr_pre[%0d]", k), k == 0 ? if24.overrun_o : if16.overrun_o,
                        1'b0);
                if (t == second_load(k))
                    chk($sformatf("ovr_set[%0d]", k), k == 0 ? if24.overrun_o : if16.overrun_o,
                        1'b1);
            end
        end
        chk("ovr_held24", if24.sample_o, word_of(0, pay[0]));
        chk("ovr_held16", if16.sample_o, word_of(1, pay[0]));
        rdy[0] = 1'b1; rdy[1] = 1'b1;
        step();
        rdy[0] = 1'b0; rdy[1] = 1'b0;
        step();
        chk("ovr_drop24", if24.sample_valid_o, 1'b0);
        chk("ovr_sticky24", if24.overrun_o, 1'b1);

        // Ready pulsed only in the cycle that loads the next word
        fill_random();
        hard_reset();
        while (t < 200) begin
            rdy[0] = (t == second_load(0) - 1);
            rdy[1] = (t == second_load(1) - 1);
            step();
            if (t == second_load(0)) begin
                chk("pulse24_valid", if24.sample_valid_o, 1'b1);
                chk("pulse24_data", if24.sample_o, word_of(0, pay[(t - 1) / 64]));
                chk("pulse24_ovr", if24.overrun_o, 1'b0);
            end
            if (t == second_load(1))
                chk("pulse16_data", if16.sample_o, word_of(1, pay[(t - 1) / 64]));
        end

        // Reset asserted at cnt=30 for five cycles
        fill_random();
        hard_reset();
        rdy[0] = 1'b1; rdy[1] = 1'b1;
        while (t < 30) step();
        reset = 1'b1;
        #1;
        model_clear();
        check_outs();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_in); #1;
            check_outs();
        end
        fill_random();
        reset = 1'b0;
        while (t < 60) begin
            step();
            if (t == 50) begin
                chk("rst_valid", if24.sample_valid_o, 1'b1);
                chk("rst_data", if24.sample_o, word_of(0, pay[0]));
            end
            if (t == 49) chk("rst_early", if24.sample_valid_o, 1'b0);
        end

        // Random payloads and random ready
        fill_random();
        hard_reset();
        for (int i = 0; i < 2000; i++) begin
            rdy[0] = ($urandom_range(0, 3) != 0);
            rdy[1] = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
